// File: rtl/wbuart_mux_fifo.sv
// wbuart_mux_fifo: arbitrates the UART byte cores between the ihex boot loader
// (byte-stream port) and a Wishbone console slave, with RX/TX FIFOs and
// status/control registers.
// Optional feature macro: WBUART_MUX_ESCAPE_EN. When defined, ESC_COUNT
// consecutive ESC_BYTE receptions in slave mode return the UART to the loader.
module wbuart_mux_fifo #(
    parameter int         FIFO_LGDEPTH = 4,
    parameter logic [7:0] ESC_BYTE     = 8'h1B,
    parameter int         ESC_COUNT    = 3,
    parameter int         WB_AW        = 30
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_stb,
    input  logic [7:0]       i_rx_data,
    output logic             o_tx_stb,
    output logic [7:0]       o_tx_data,
    input  logic             i_tx_busy,
    output logic             o_ld_rx_stb,
    output logic [7:0]       o_ld_rx_data,
    input  logic             i_ld_tx_stb,
    input  logic [7:0]       i_ld_tx_data,
    output logic             o_ld_tx_busy,
    output logic             o_ld_reset,
    output logic             o_slave_mode,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [3:0]       i_wb_sel,
    input  logic [WB_AW-1:0] i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic             o_wb_err,
    output logic [31:0]      o_wb_data
);
    localparam int CW    = FIFO_LGDEPTH + 1;
    localparam int DEPTH = 1 << FIFO_LGDEPTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          slave_mode_q, slave_mode_d;
    logic          rx_ovf_q, rx_ovf_d;
    logic          tx_drop_q, tx_drop_d;
    logic          holdoff_q, holdoff_d;
    logic          wb_ack_q, wb_ack_d;
    logic          wb_err_q, wb_err_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [CW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];

    logic [CW-1:0] rx_cnt, tx_cnt;
    logic          rx_empty, rx_full, tx_empty, tx_full;
    logic [7:0]    rx_head, tx_head;
    logic          wb_req;
    logic [1:0]    wb_a;
    logic          rx_push, rx_pop, tx_push, tx_pop, flush;
    logic [31:0]   status;
    logic          esc_fire;
    logic          sig_unused;

    assign rx_cnt   = rx_wr_q - rx_rd_q;
    assign tx_cnt   = tx_wr_q - tx_rd_q;
    assign rx_empty = (rx_cnt == '0);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign rx_head  = rx_mem_q[rx_rd_q[FIFO_LGDEPTH-1:0]];
    assign tx_head  = tx_mem_q[tx_rd_q[FIFO_LGDEPTH-1:0]];
    assign wb_req   = i_wb_cyc & i_wb_stb;
    assign wb_a     = i_wb_addr[1:0];

    // One byte per strobe; holdoff leaves uart_tx a cycle to raise busy.
    assign tx_pop    = slave_mode_q & ~tx_empty & ~i_tx_busy & ~holdoff_q;
    assign holdoff_d = tx_pop;

    assign o_slave_mode = slave_mode_q;
    assign o_ld_reset   = i_reset | slave_mode_q;
    assign o_ld_rx_stb  = ~slave_mode_q & i_rx_stb;
    assign o_ld_rx_data = i_rx_data;
    assign o_ld_tx_busy = slave_mode_q | i_tx_busy;
    assign o_tx_stb     = ~i_reset & (slave_mode_q ? tx_pop : i_ld_tx_stb);
    assign o_tx_data    = slave_mode_q ? tx_head : i_ld_tx_data;
    assign o_wb_stall   = 1'b0;
    assign o_wb_ack     = wb_ack_q;
    assign o_wb_err     = wb_err_q;
    assign o_wb_data    = wb_data_q;

`ifdef WBUART_MUX_ESCAPE_EN
    logic [3:0] esc_cnt_q, esc_cnt_d;

    // The escape fires the cycle after the count is reached, so the last ESC is already queued.
    assign esc_fire = (esc_cnt_q == 4'(ESC_COUNT));

    // Count consecutive escape bytes received while the Wishbone side owns the UART.
    always_comb begin
        esc_cnt_d = esc_cnt_q;
        if (esc_fire)
            esc_cnt_d = 4'd0;
        else if (slave_mode_q && i_rx_stb)
            esc_cnt_d = (i_rx_data == ESC_BYTE) ? esc_cnt_q + 4'd1 : 4'd0;
    end

    // Escape counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) esc_cnt_q <= 4'd0;
        else         esc_cnt_q <= esc_cnt_d;
    end

    assign sig_unused = ^{i_wb_addr[WB_AW-1:2], i_wb_sel[3:1], i_wb_data[31:8]};
`else
    assign esc_fire   = 1'b0;
    assign sig_unused = ^{i_wb_addr[WB_AW-1:2], i_wb_sel[3:1], i_wb_data[31:8],
                          ESC_BYTE, 4'(ESC_COUNT)};
`endif

    // Register decode, FIFO push/pop/flush and next-state for all control state.
    always_comb begin
        slave_mode_d = slave_mode_q;
        rx_ovf_d     = rx_ovf_q;
        tx_drop_d    = tx_drop_q;
        wb_ack_d     = wb_req & (wb_a != 2'd3);
        wb_err_d     = wb_req & (wb_a == 2'd3);
        wb_data_d    = 32'd0;
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        flush        = 1'b0;

        status        = 32'd0;
        status[31]    = slave_mode_q;
        status[30]    = rx_ovf_q;
        status[29]    = tx_drop_q;
        status[28]    = rx_empty;
        status[27]    = tx_full;
        status[23:16] = 8'(rx_cnt);
        status[15:8]  = 8'(tx_cnt);

        if (wb_req && !i_wb_we) begin
            case (wb_a)
                2'd0: begin
                    wb_data_d = {23'd0, rx_empty, rx_empty ? 8'h00 : rx_head};
                    rx_pop    = ~rx_empty;
                end
                2'd1:    wb_data_d = status;
                2'd2:    wb_data_d = {31'd0, slave_mode_q};
                default: wb_data_d = 32'd0;
            endcase
        end

        if (wb_req && i_wb_we && i_wb_sel[0]) begin
            if (wb_a == 2'd0) begin
                // A console write claims the UART even from loader mode.
                slave_mode_d = 1'b1;
                tx_push      = ~tx_full | tx_pop;
                if (tx_full && !tx_pop) tx_drop_d = 1'b1;
            end else if (wb_a == 2'd2) begin
                slave_mode_d = i_wb_data[0];
                if (slave_mode_q && !i_wb_data[0]) flush = 1'b1;
                if (i_wb_data[2]) flush = 1'b1;
                if (i_wb_data[1]) begin
                    rx_ovf_d  = 1'b0;
                    tx_drop_d = 1'b0;
                end
            end
        end

        // A pop in the same cycle makes room, so a full FIFO still accepts the byte.
        rx_push = slave_mode_q & i_rx_stb & (~rx_full | rx_pop);
        if (slave_mode_q && i_rx_stb && rx_full && !rx_pop) rx_ovf_d = 1'b1;

        if (esc_fire) begin
            slave_mode_d = 1'b0;
            flush        = 1'b1;
        end

        if (flush) begin
            rx_wr_d = '0;
            rx_rd_d = '0;
            tx_wr_d = '0;
            tx_rd_d = '0;
        end else begin
            rx_wr_d = rx_wr_q + CW'(rx_push);
            rx_rd_d = rx_rd_q + CW'(rx_pop);
            tx_wr_d = tx_wr_q + CW'(tx_push);
            tx_rd_d = tx_rd_q + CW'(tx_pop);
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (rx_push) rx_mem_q[rx_wr_q[FIFO_LGDEPTH-1:0]] <= i_rx_data;
        if (tx_push) tx_mem_q[tx_wr_q[FIFO_LGDEPTH-1:0]] <= i_wb_data[7:0];
    end

    // Control and bus-response registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            slave_mode_q <= 1'b0;
            rx_ovf_q     <= 1'b0;
            tx_drop_q    <= 1'b0;
            holdoff_q    <= 1'b0;
            wb_ack_q     <= 1'b0;
            wb_err_q     <= 1'b0;
            wb_data_q    <= 32'd0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
        end else begin
            slave_mode_q <= slave_mode_d;
            rx_ovf_q     <= rx_ovf_d;
            tx_drop_q    <= tx_drop_d;
            holdoff_q    <= holdoff_d;
            wb_ack_q     <= wb_ack_d;
            wb_err_q     <= wb_err_d;
            wb_data_q    <= wb_data_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
        end
    end
endmodule

// File: doc/wbuart_mux_fifo.md
Name: wbuart_mux_fifo

Overview:
Successor UART arbiter/buffer sitting between the uart_rx/uart_tx byte cores and two users: the ihex boot loader (byte-stream port) and a Wishbone slave (CPU console).
- Adds parametrised-depth RX/TX FIFOs, status/control registers and explicit mode control.
- Adds an optional in-band escape sequence that hands the UART back to the loader without a reset.

Parameters:
- FIFO_LGDEPTH, 4: log2 of RX and TX FIFO depth; legal 1..7.
- ESC_BYTE, 8'h1B: escape character.
- ESC_COUNT, 3: consecutive ESC_BYTE receptions that trigger return to loader mode; legal 1..15.
- WB_AW, 30: Wishbone word-address width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_rx_stb  in  1  one-cycle strobe from uart_rx, byte valid
- i_rx_data  in  8  received byte
- o_tx_stb  out  1  start-transmit strobe to uart_tx
- o_tx_data  out  8  byte to transmit
- i_tx_busy  in  1  uart_tx busy
- o_ld_rx_stb  out  1  received byte strobe to loader
- o_ld_rx_data  out  8  received byte to loader
- i_ld_tx_stb  in  1  loader transmit strobe
- i_ld_tx_data  in  8  loader transmit byte
- o_ld_tx_busy  out  1  busy seen by loader
- o_ld_reset  out  1  loader held in reset
- o_slave_mode  out  1  1 = Wishbone owns UART
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone slave control
- i_wb_sel  in  4  byte select
- i_wb_addr  in  WB_AW  word address; only [1:0] decoded
- i_wb_data  in  32  write data
- o_wb_stall  out  1  constant 0
- o_wb_ack  out  1  acknowledge
- o_wb_err  out  1  error
- o_wb_data  out  32  read data

Behaviour:
- Reset and clock: reset i_reset, synchronous, active-high; clock i_clk.
- Reset values: slave_mode=0, FIFOs empty, sticky flags 0, escape counter 0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_tx_stb=0.
- Loader mode (slave_mode=0):
  - o_ld_rx_stb=i_rx_stb and o_ld_rx_data=i_rx_data, combinational.
  - o_tx_stb/o_tx_data pass through from i_ld_tx_*; o_ld_tx_busy=i_tx_busy.
  - RX FIFO is not written.
  - o_ld_reset=i_reset|slave_mode, combinational.
- Slave mode:
  - o_ld_rx_stb=0 and o_ld_tx_busy=1.
  - Each i_rx_stb pushes into the RX FIFO. If the FIFO is full, the byte is dropped and rx_ovf is set (sticky).
- TX drain (slave mode):
  - o_tx_stb pulses for exactly one cycle when the TX FIFO is non-empty, i_tx_busy=0, and holdoff=0. o_tx_data is the FIFO head, popped in the same cycle.
  - holdoff is forced to 1 for the following cycle so uart_tx busy can assert.
- Wishbone timing: single-cycle ack, registered, one cycle after i_wb_stb&i_wb_cyc; o_wb_stall=0; one outstanding request per cycle accepted.
- Register map by i_wb_addr[1:0]:
  - Addr 3: ack with o_wb_err=1 instead of o_wb_ack, no side effects.
- Addr 0, DATA:
  - Write with i_wb_sel[0] while in loader mode: set slave_mode=1 in the same cycle, then push data[7:0].
  - Write with i_wb_sel[0] while in slave mode: push data[7:0].
  - TX FIFO full: drop the byte and set tx_drop (sticky).
  - Read: returns {23'b0, rx_empty, head}. The head is popped only if the FIFO is non-empty; when empty, data[7:0] = 0.
- Addr 1, STATUS (read-only; writes acked and ignored):
  - [31] slave_mode, [30] rx_ovf, [29] tx_drop, [28] rx_empty, [27] tx_full
  - [23:16] rx_count, [15:8] tx_count, zero-extended from FIFO_LGDEPTH+1 bits
  - all other bits 0
- Addr 2, CONTROL (write with i_wb_sel[0]):
  - bit0 = new slave_mode. 1→0 flushes both FIFOs.
  - bit1 = 1 clears rx_ovf and tx_drop.
  - bit2 = 1 flushes both FIFOs.
  - Reads return {29'b0, 2'b0, slave_mode}.
- FIFO counts:
  - Simultaneous push and pop on a non-empty FIFO: both occur, count unchanged.
  - Push to a full FIFO with a simultaneous pop: allowed; no overflow is flagged.
  - Pointers wrap modulo 2^FIFO_LGDEPTH.
  - A flush has priority over a same-cycle push/pop.
- Mode change mid-transaction: the pending ack is still delivered. A TX byte already strobed completes; uart_tx owns it.
- Reset mid-operation: all state returns to reset values in the next cycle; an in-flight ack is lost.

Optional Feature:
WBUART_MUX_ESCAPE_EN
- Defined:
  - In slave mode, esc_cnt increments on each received ESC_BYTE and clears on any other received byte.
  - When a reception makes esc_cnt reach ESC_COUNT, the next cycle sets slave_mode=0, flushes both FIFOs and clears esc_cnt.
  - Escape bytes are pushed normally before the flush.
  - Same-cycle CONTROL write vs escape: the escape wins.
- Undefined: no escape logic; only CONTROL bit0 or reset leaves slave mode.

Test Plan:
- Loader passthrough: reset; rx bytes 0x3A,0x31 -> o_ld_rx_stb pulses with the same data; i_ld_tx_stb 0x2E -> o_tx_stb/o_tx_data=0x2E same cycle; STATUS[31]=0.
- Mode entry: WB write DATA=0x41 -> STATUS[31]=1, o_ld_reset=1, o_tx_stb carries 0x41 once i_tx_busy=0; later i_rx_stb 0x55 -> DATA read returns 0x00000055, then 0x00000100.
- RX overflow (FIFO_LGDEPTH=2): 5 rx bytes, no reads -> rx_count=4, STATUS[30]=1; CONTROL=0x2 clears it; reads return the first 4 bytes in order.
- TX full with busy held high: 17 DATA writes (depth 16) -> tx_count=16, STATUS[29]=1; release busy -> 16 strobes, each followed by at least 1 idle cycle.
- Address 3 read -> o_wb_err=1, o_wb_ack=0; simultaneous rx push and DATA pop with 3 queued -> rx_count stays 3.
- With WBUART_MUX_ESCAPE_EN, ESC_COUNT=3: rx 1B,1B,41,1B,1B,1B -> slave_mode drops after the 6th byte only, FIFOs empty, next rx byte appears on o_ld_rx_stb.
